int_arbiter: RTL
================

# int_arbiter

Round-robin arbiter that shares the core's single external-interrupt entry between `NUM_SRC` peripheral interrupt sources. It sits between the SoC peripherals and the core's interrupt controller. It latches and masks requests and presents exactly one one-hot request on `int_flag_o`. It then tracks that source through a claim/complete handshake performed by the trap handler over a small memory-mapped register window.

## Interface

Parameters:
- `NUM_SRC`, 14: number of interrupt sources, range 1..31; matches `INT_BUS` width.
- `EDGE_MASK`, 14'h0000: bit i = 1 makes source i rising-edge triggered; 0 makes it level triggered.

Ports:
- `clk`, input, 1: core clock.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `irq_i`, input, NUM_SRC: raw interrupt lines, already synchronous to `clk`.
- `int_flag_o`, output, NUM_SRC: one-hot request to the core interrupt controller; all-zero when no request.
- `we_i`, input, 1: register write strobe.
- `re_i`, input, 1: register read strobe.
- `addr_i`, input, 4: byte offset; only `[3:2]` is decoded.
- `wdata_i`, input, 32: write data.
- `rdata_o`, output, 32: read data, registered.

## Operation

Registers, by `addr_i[3:2]`:
- 0, PENDING (RO): pending vector, zero-extended.
- 1, ENABLE (RW): enable mask, reset 0. Bits ≥ NUM_SRC are ignored on write and read as 0.
- 2, CLAIM (R with side effect): returns ID = index+1 of the presented source, or 0 if none. A claim marks that source in service.
- 3, COMPLETE (W): a write of the in-service ID ends service. Mismatched IDs and writes in other states are ignored. Reads return 0.

Pending rules:
- Edge source: pending is set when `irq_i` goes 0→1, detected against a registered copy `irq_q`. It is cleared by a claim of that source. If set and clear land in the same cycle, set wins.
- Level source: pending equals `irq_i`. A claim does not clear it.

Eligibility:
- eligible = pending & ENABLE & ~in_service_mask.
- Winner is the first eligible index searching upward from `last_id+1` and wrapping at NUM_SRC-1 → 0.
- `last_id` resets to NUM_SRC-1, so index 0 has first priority after reset. It updates to the winner on claim.

FSM states and transitions:
- IDLE: if eligible ≠ 0, latch the winner into `cur_id` and go to PRESENT.
- PRESENT: `int_flag_o = 1 << cur_id`.
  - A CLAIM read goes to SERVICE.
  - If `cur_id` loses ENABLE, or (level source) its `irq_i` drops, go to IDLE. `int_flag_o` clears on the same edge.
- SERVICE: `int_flag_o = 0`. A COMPLETE write with ID = `cur_id`+1 goes to IDLE.

Only one source is in service at a time; there is no nesting. ENABLE writes are accepted in every state.

## Timing

Reset values:
- `int_flag_o` = 0, `rdata_o` = 0.
- FSM = IDLE; pending, ENABLE, `irq_q`, `cur_id` = 0.
- `last_id` = NUM_SRC-1.

Latency and ordering:
- `irq_i` rise sampled at edge N (enabled, IDLE): pending = 1 after edge N; `int_flag_o` valid after edge N+1.
- Read data appears on `rdata_o` the cycle after `re_i`. The CLAIM side effects (state change, pending clear, `last_id` update) commit on the same edge that samples `re_i`.
- COMPLETE → IDLE on the write edge. The next winner is presented one cycle later.
- `we_i` and `re_i` in the same cycle: the write is performed and the read returns pre-write data.
- Asynchronous reset mid-operation returns everything to reset values immediately; in-flight claims are lost.

## Structure

- Shared defines in `yadan_defs.v`:
  - Register offsets `INTARB_PENDING`/`ENABLE`/`CLAIM`/`COMPLETE` (4'h0/4'h4/4'h8/4'hC).
  - FSM encodings IDLE/PRESENT/SERVICE.
  - `INTARB_NO_ID` = 0.
- One sub-module, `rr_pick`: combinational round-robin priority picker. Inputs are the request vector and `last_id`; outputs are a valid flag and the winner index. It is reusable for other shared resources.

## Test plan

1. Reset, ENABLE=14'h0001, edge pulse on `irq_i[0]` at edge 5 → `int_flag_o`=14'h0001 after edge 6; CLAIM read returns 1; PENDING reads 0; `int_flag_o`=0.
2. ENABLE=all, edge pulses on sources 2 and 5 in the same cycle → 2 presented first. After claim and COMPLETE(3), 5 is presented. Re-pulse 2 and 5 → 5 is not preferred, since `last_id`=5 wraps the search to 2 first.
3. Level source 3 held high, enabled, claimed and completed while still high → re-presented one cycle after COMPLETE. Dropping `irq_i[3]` in PRESENT → `int_flag_o`=0 the next cycle.
4. PRESENT on source 4, then ENABLE bit 4 is cleared → IDLE and `int_flag_o`=0. Pending bit 4 stays 1 (edge source).
5. COMPLETE with the wrong ID in SERVICE → stays in SERVICE. CLAIM read in IDLE returns 0 with no state change.
6. Assert `rst_n` low during SERVICE → all outputs and registers return to reset values asynchronously. After release, the first pulse is handled per scenario 1.

Source files
------------

// File: rtl/int_arbiter_pkg.sv
// Shared constants for the interrupt arbiter: register offsets, FSM encodings
// and the source-index/ID helpers.
package int_arbiter_pkg;

  localparam int INTARB_IW = 5;

  localparam logic [3:0] INTARB_PENDING  = 4'h0;
  localparam logic [3:0] INTARB_ENABLE   = 4'h4;
  localparam logic [3:0] INTARB_CLAIM    = 4'h8;
  localparam logic [3:0] INTARB_COMPLETE = 4'hC;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_PRESENT = 2'd1;
  localparam logic [1:0] ST_SERVICE = 2'd2;

  localparam logic [INTARB_IW-1:0] INTARB_NO_ID = 5'd0;

  // IDs seen by software are index+1 so that 0 can mean "no source"
  function automatic logic [INTARB_IW-1:0] id_of(input logic [INTARB_IW-1:0] idx);
    return idx + 5'd1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request searching upward from
// last_id+1, wrapping at N-1 back to 0.
module rr_pick #(
  parameter int N  = 14,
  parameter int IW = 5
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last_id,
  output logic          valid,
  output logic [IW-1:0] winner
);

  // distance 0 is the slot right after last_id; the smallest requested distance wins
  always_comb begin
    int best_d;
    int d;
    logic hit;
    best_d = N;
    d      = 0;
    hit    = 1'b0;
    valid  = 1'b0;
    winner = '0;
    for (int i = 0; i < N; i++) begin
      d      = (i + N - 1 - int'(last_id)) % N;
      hit    = req[i] && (d < best_d);
      best_d = hit ? d : best_d;
      winner = hit ? IW'(i) : winner;
      valid  = valid | hit;
    end
  end

endmodule

// File: rtl/int_arbiter.sv
// Round-robin interrupt arbiter: shares one core interrupt entry between
// NUM_SRC sources with a claim/complete register handshake.
module int_arbiter
  import int_arbiter_pkg::*;
#(
  parameter int                 NUM_SRC   = 14,
  parameter logic [NUM_SRC-1:0] EDGE_MASK = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_SRC-1:0] irq_i,
  output logic [NUM_SRC-1:0] int_flag_o,
  input  logic               we_i,
  input  logic               re_i,
  input  logic [3:0]         addr_i,
  input  logic [31:0]        wdata_i,
  output logic [31:0]        rdata_o
);

  localparam logic [NUM_SRC-1:0] SRC_ONE = NUM_SRC'(1'b1);

  logic [NUM_SRC-1:0]   irq_q_r, edge_pend_r, enable_r, int_flag_r;
  logic [NUM_SRC-1:0]   pending_s, eligible_s, enable_nxt_s, cur_oh_s, win_oh_s;
  logic [NUM_SRC-1:0]   in_svc_s, flag_nxt_s;
  logic [1:0]           state_r, state_nxt_s, sel_s;
  logic [INTARB_IW-1:0] cur_id_r, last_id_r, win_id_s;
  logic [31:0]          rdata_r, rdata_nxt_s;
  logic                 win_valid_s, claim_s, complete_s, wr_enable_s, cur_lost_s;
  logic                 unused_s;

  assign sel_s    = addr_i[3:2];
  assign unused_s = ^addr_i[1:0];

  assign wr_enable_s  = we_i && (sel_s == INTARB_ENABLE[3:2]);
  assign claim_s      = re_i && (sel_s == INTARB_CLAIM[3:2]) && (state_r == ST_PRESENT);
  assign complete_s   = we_i && (sel_s == INTARB_COMPLETE[3:2]) && (state_r == ST_SERVICE)
                        && (wdata_i == {27'd0, id_of(cur_id_r)});
  assign enable_nxt_s = wr_enable_s ? wdata_i[NUM_SRC-1:0] : enable_r;

  assign cur_oh_s   = SRC_ONE << cur_id_r;
  assign win_oh_s   = SRC_ONE << win_id_s;
  assign in_svc_s   = (state_r == ST_SERVICE) ? cur_oh_s : '0;
  assign pending_s  = (edge_pend_r & EDGE_MASK) | (irq_i & ~EDGE_MASK);
  assign eligible_s = pending_s & enable_r & ~in_svc_s;

  // presented source is withdrawn if disabled (including this cycle's write) or its level drops
  assign cur_lost_s = ~|(enable_nxt_s & cur_oh_s)
                      || (~|(cur_oh_s & EDGE_MASK) && ~|(cur_oh_s & irq_i));

  rr_pick #(
    .N  (NUM_SRC),
    .IW (INTARB_IW)
  ) u_pick (
    .req     (eligible_s),
    .last_id (last_id_r),
    .valid   (win_valid_s),
    .winner  (win_id_s)
  );

  // next-state logic for the present/claim/complete handshake
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (win_valid_s) state_nxt_s = ST_PRESENT;
        else             state_nxt_s = ST_IDLE;
      end
      ST_PRESENT: begin
        if (claim_s)         state_nxt_s = ST_SERVICE;
        else if (cur_lost_s) state_nxt_s = ST_IDLE;
        else                 state_nxt_s = ST_PRESENT;
      end
      ST_SERVICE: begin
        if (complete_s) state_nxt_s = ST_IDLE;
        else            state_nxt_s = ST_SERVICE;
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // request flag follows the state it is entering
  always_comb begin
    flag_nxt_s = '0;
    if (state_nxt_s == ST_PRESENT) begin
      if (state_r == ST_IDLE) flag_nxt_s = win_oh_s;
      else                    flag_nxt_s = cur_oh_s;
    end else begin
      flag_nxt_s = '0;
    end
  end

  // read mux; reads see pre-edge values, so a same-cycle write is not visible
  always_comb begin
    rdata_nxt_s = rdata_r;
    if (re_i) begin
      case (sel_s)
        INTARB_PENDING[3:2]: rdata_nxt_s = {{(32-NUM_SRC){1'b0}}, pending_s};
        INTARB_ENABLE[3:2]:  rdata_nxt_s = {{(32-NUM_SRC){1'b0}}, enable_r};
        INTARB_CLAIM[3:2]: begin
          if (state_r == ST_PRESENT) rdata_nxt_s = {27'd0, id_of(cur_id_r)};
          else                       rdata_nxt_s = {27'd0, INTARB_NO_ID};
        end
        default: rdata_nxt_s = 32'd0;
      endcase
    end else begin
      rdata_nxt_s = rdata_r;
    end
  end

  // FSM, source tracking and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= ST_IDLE;
      cur_id_r   <= '0;
      last_id_r  <= INTARB_IW'(NUM_SRC - 1);
      int_flag_r <= '0;
      rdata_r    <= 32'd0;
    end else begin
      state_r    <= state_nxt_s;
      int_flag_r <= flag_nxt_s;
      rdata_r    <= rdata_nxt_s;
      if (state_r == ST_IDLE && win_valid_s) cur_id_r <= win_id_s;
      if (claim_s) last_id_r <= cur_id_r;
    end
  end

  // edge capture and enable mask; a new rise beats a same-cycle claim clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irq_q_r     <= '0;
      edge_pend_r <= '0;
      enable_r    <= '0;
    end else begin
      irq_q_r     <= irq_i;
      edge_pend_r <= ((edge_pend_r & ~(claim_s ? cur_oh_s : '0)) | (irq_i & ~irq_q_r)) & EDGE_MASK;
      enable_r    <= enable_nxt_s;
    end
  end

  assign int_flag_o = int_flag_r;
  assign rdata_o    = rdata_r;

endmodule
